// File: rtl/if_id_queue.sv
// IF->ID instruction queue: circular buffer of {pc, pc4, inst} with ready/valid on both sides.
// Optional same-cycle bypass when empty is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_pc,
  input  logic [DW-1:0]            in_pc4,
  input  logic [DW-1:0]            in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_pc,
  output logic [DW-1:0]            out_pc4,
  output logic [DW-1:0]            out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
    logic [DW-1:0] inst;
  } entry_t;

  entry_t         mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic [CW-1:0]  count_next;

  logic           full;
  logic           empty;
  logic           stored_valid;
  logic           bypass;
  logic           push;
  logic           pop;
  logic [DEPTH-1:0] wr_en;
  entry_t         in_entry;
  entry_t         head_entry;
  entry_t         out_entry;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // Ready/valid are both gated by reset so nothing handshakes while reset is held.
  assign in_ready     = cpu_rst && !full && !flush;
  assign stored_valid = cpu_rst && !empty && !flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = cpu_rst && empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign in_entry   = '{pc: in_pc, pc4: in_pc4, inst: in_inst};
  assign head_entry = mem_reg[rd_ptr_reg];
  assign out_entry  = bypass ? in_entry : head_entry;

  assign out_valid = stored_valid || bypass;
  assign out_pc    = out_entry.pc;
  assign out_pc4   = out_entry.pc4;
  assign out_inst  = out_entry.inst;
  assign count     = count_reg;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign push = in_valid && in_ready && !(bypass && out_ready);
  assign pop  = stored_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= in_entry;
        end
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-based reference model checked every cycle plus directed scenarios.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_pc4;
  logic [DW-1:0] in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_pc4;
  logic [DW-1:0] out_inst;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
    logic [DW-1:0] inst;
  } ent_t;

  ent_t          model_q[$];
  logic [DW-1:0] popped[$];
  int            checks = 0;
  int            errors = 0;

  if_id_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst),
    .count(count)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated on the falling edge against the inputs held for the next rising edge.
  always @(negedge cpu_clk) begin : cmp
    logic byp, eir, eov, epop, epush;
    ent_t eh, ein;
    ein.pc = in_pc; ein.pc4 = in_pc4; ein.inst = in_inst;
    byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    byp = cpu_rst && !flush && in_valid && (model_q.size() == 0);
`endif
    eir = cpu_rst && !flush && (model_q.size() < DEPTH);
    eov = cpu_rst && !flush && ((model_q.size() > 0) || byp);
    chk("in_ready", 64'(in_ready), 64'(eir));
    chk("out_valid", 64'(out_valid), 64'(eov));
    chk("count", 64'(count), cpu_rst ? 64'(model_q.size()) : 64'd0);
    eh = ein;
    if (eov) begin
      if (!byp) eh = model_q[0];
      chk("out_pc", 64'(out_pc), 64'(eh.pc));
      chk("out_pc4", 64'(out_pc4), 64'(eh.pc4));
      chk("out_inst", 64'(out_inst), 64'(eh.inst));
    end
    if (!cpu_rst || flush) begin
      model_q.delete();
    end else begin
      epop  = eov && out_ready;
      epush = in_valid && eir;
      if (epop) popped.push_back(eh.pc);
      if (!(byp && out_ready)) begin
        if (epop) void'(model_q.pop_front());
        if (epush) model_q.push_back(ein);
      end
    end
  end

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive_in(input logic [DW-1:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_pc4   = pc + 32'd4;
    in_inst  = 32'h00000013 ^ (pc << 7);
  endtask

  // Hold an entry until it is accepted, then drop in_valid.
  task automatic send(input logic [DW-1:0] pc);
    bit acc = 1'b0;
    drive_in(pc);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge cpu_clk);
      acc = in_ready;
      step();
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 60 && popped.size() < n; i++) step();
    if (popped.size() < n) chk("drain_timeout", 64'(popped.size()), 64'(n));
  endtask

  initial begin
    cpu_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_pc4 = '0; in_inst = '0;

    // Reset held 3 cycles, then idle
    @(negedge cpu_clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    step(); step(); step();
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_pc", 64'(out_pc), 64'd0);
    step();

    // Fill to full, hold a 5th entry, then drain in order
    popped.delete();
    for (int k = 0; k < 4; k++) send(32'(k * 4));
    drive_in(32'h10);
    @(negedge cpu_clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step();
    @(negedge cpu_clk);
    chk("full_hold_count", 64'(count), 64'd4);
    step();
    out_ready = 1'b1;
    send(32'h10);
    drain(5);
    for (int k = 0; k < 5; k++) chk("fill_drain_order", 64'(popped[k]), 64'(k * 4));

    // Simultaneous push/pop at count=2
    out_ready = 1'b0;
    popped.delete();
    send(32'h18);
    send(32'h1c);
    drive_in(32'h20);
    out_ready = 1'b1;
    @(negedge cpu_clk);
    chk("pp_count_before", 64'(count), 64'd2);
    chk("pp_head_before", 64'(out_pc), 64'h18);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge cpu_clk);
    chk("pp_count_after", 64'(count), 64'd2);
    chk("pp_head_after", 64'(out_pc), 64'h1c);
    step();
    out_ready = 1'b1;
    drain(3);
    chk("pp_pop0", 64'(popped[0]), 64'h18);
    chk("pp_pop1", 64'(popped[1]), 64'h1c);
    chk("pp_pop2", 64'(popped[2]), 64'h20);

    // Flush with count=3 and a pending input
    out_ready = 1'b0;
    send(32'h30); send(32'h34); send(32'h38);
    drive_in(32'h40);
    flush = 1'b1;
    @(negedge cpu_clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_count_before", 64'(count), 64'd3);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge cpu_clk);
    chk("flush_count_after", 64'(count), 64'd0);
    step();
    popped.delete();
    send(32'h80);
    out_ready = 1'b1;
    drain(1);
    chk("flush_first_out", 64'(popped[0]), 64'h80);

    // Pointer wrap: 10 entries streamed through
    popped.delete();
    for (int k = 0; k < 10; k++) send(32'h100 + 32'(4 * k));
    drain(10);
    for (int k = 0; k < 10; k++) chk("wrap_order", 64'(popped[k]), 64'(32'h100 + 32'(4 * k)));

    // Empty queue, same-cycle in_valid and out_ready
    step();
    popped.delete();
    drive_in(32'h200);
    @(negedge cpu_clk);
`ifdef IF_ID_QUEUE_BYPASS_EN
    chk("byp_out_valid", 64'(out_valid), 64'd1);
    chk("byp_out_pc", 64'(out_pc), 64'h200);
`else
    chk("nobyp_out_valid", 64'(out_valid), 64'd0);
`endif
    step();
    in_valid = 1'b0;
    @(negedge cpu_clk);
`ifdef IF_ID_QUEUE_BYPASS_EN
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_out_valid_next", 64'(out_valid), 64'd0);
`else
    chk("nobyp_count", 64'(count), 64'd1);
    chk("nobyp_out_valid_next", 64'(out_valid), 64'd1);
    chk("nobyp_out_pc_next", 64'(out_pc), 64'h200);
`endif
    step();
    drain(1);
    chk("byp_popped", 64'(popped[0]), 64'h200);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send(32'h300); send(32'h304);
    cpu_rst = 1'b0;
    #2;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    step();
    cpu_rst = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      flush     = ($urandom_range(0, 29) == 0);
      cpu_rst   = ($urandom_range(0, 299) != 0);
      in_pc     = $urandom;
      in_pc4    = in_pc + 32'd4;
      in_inst   = $urandom;
      step();
    end
    cpu_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
